// File: rtl/pc_sequencer.sv
// KGP-miniRISC program counter and FETCH/EXEC/HALT fetch sequencer.
// Optional feature macro PC_ALIGN_CHECK_EN: trap misaligned br targets into HALT with a sticky flag.
module pc_sequencer #(
    parameter int                  PC_WIDTH    = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter logic [5:0]          HALT_OPCODE = 6'b111111
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                imem_ready,
    input  logic [31:0]         imem_rdata,
    input  logic                branch_valid,
    input  logic [31:0]         rs_value,
    input  logic [31:0]         imm_offset,
    input  logic                stall,
    output logic [PC_WIDTH-1:0] pc,
    output logic                imem_req,
    output logic [31:0]         instr,
    output logic                instr_valid,
    output logic                link_we,
    output logic [31:0]         link_value,
    output logic                halted,
    output logic                misalign_err
);

    localparam logic [5:0] OP_BR = 6'b001010;
    localparam logic [5:0] OP_BL = 6'b001100;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_HALT} state_t;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [31:0]         instr_q, instr_d;
    logic                imem_req_q, imem_req_d;
    logic                instr_valid_q, instr_valid_d;
    logic                link_we_q, link_we_d;
    logic [31:0]         link_value_q, link_value_d;
    logic                halted_q, halted_d;

    logic [5:0]          opcode;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic [PC_WIDTH-1:0] rel_target;
    logic [PC_WIDTH-1:0] reg_target;
    logic [PC_WIDTH-1:0] next_pc;
    logic                misalign_hit;

    assign opcode     = instr_q[31:26];
    assign pc_plus4   = pc_q + PC_WIDTH'(4);
    assign rel_target = pc_plus4 + PC_WIDTH'(imm_offset << 2);

`ifdef PC_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;

    assign reg_target   = PC_WIDTH'(rs_value);
    assign misalign_hit = branch_valid && (opcode == OP_BR) && (rs_value[1:0] != 2'b00);
    assign misalign_err = misalign_q;
`else
    // Low target bits are dropped so a register jump always lands on a word.
    assign reg_target   = PC_WIDTH'(rs_value & ~32'h3);
    assign misalign_hit = 1'b0;
    assign misalign_err = 1'b0;
`endif

    always_comb begin
        next_pc = pc_plus4;
        if (branch_valid) begin
            next_pc = (opcode == OP_BR) ? reg_target : rel_target;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        link_we_d    = 1'b0;
        link_value_d = link_value_q;
`ifdef PC_ALIGN_CHECK_EN
        misalign_d   = misalign_q;
`endif
        case (state_q)
            S_FETCH: begin
                if (imem_ready) begin
                    instr_d = imem_rdata;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!stall) begin
                    if (opcode == HALT_OPCODE) begin
                        state_d = S_HALT;
                    end else if (misalign_hit) begin
`ifdef PC_ALIGN_CHECK_EN
                        misalign_d = 1'b1;
`endif
                        state_d = S_HALT;
                    end else begin
                        state_d = S_FETCH;
                        pc_d    = next_pc;
                        if (opcode == OP_BL) begin
                            link_we_d    = 1'b1;
                            link_value_d = 32'(pc_plus4);
                        end
                    end
                end
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
        // Status outputs are registered copies of the next state.
        imem_req_d    = (state_d == S_FETCH);
        instr_valid_d = (state_d == S_EXEC);
        halted_d      = (state_d == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_FETCH;
            pc_q          <= RESET_PC;
            instr_q       <= '0;
            imem_req_q    <= 1'b1;
            instr_valid_q <= 1'b0;
            link_we_q     <= 1'b0;
            link_value_q  <= '0;
            halted_q      <= 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            imem_req_q    <= imem_req_d;
            instr_valid_q <= instr_valid_d;
            link_we_q     <= link_we_d;
            link_value_q  <= link_value_d;
            halted_q      <= halted_d;
`ifdef PC_ALIGN_CHECK_EN
            misalign_q    <= misalign_d;
`endif
        end
    end

    assign pc          = pc_q;
    assign imem_req    = imem_req_q;
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign link_we     = link_we_q;
    assign link_value  = link_value_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, fetch wait, branches, bl with stall, br, halt, reset.
module tb_pc_sequencer;

    localparam logic [5:0] OP_ALU  = 6'b000001;
    localparam logic [5:0] OP_BZ   = 6'b000100;
    localparam logic [5:0] OP_BR   = 6'b001010;
    localparam logic [5:0] OP_BL   = 6'b001100;
    localparam logic [5:0] OP_HALT = 6'b111111;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        branch_valid;
    logic [31:0] rs_value;
    logic [31:0] imm_offset;
    logic        stall;
    logic [31:0] pc;
    logic        imem_req;
    logic [31:0] instr;
    logic        instr_valid;
    logic        link_we;
    logic [31:0] link_value;
    logic        halted;
    logic        misalign_err;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .branch_valid (branch_valid),
        .rs_value     (rs_value),
        .imm_offset   (imm_offset),
        .stall        (stall),
        .pc           (pc),
        .imem_req     (imem_req),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .link_we      (link_we),
        .link_value   (link_value),
        .halted       (halted),
        .misalign_err (misalign_err)
    );

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One FETCH cycle with memory ready; leaves the sequencer in EXEC.
    task automatic fetch(input logic [5:0] op);
        imem_ready = 1'b1;
        imem_rdata = {op, 26'h0000ABC};
        tick();
        imem_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1; imem_ready = 1'b0; imem_rdata = '0; branch_valid = 1'b0;
        rs_value = '0; imm_offset = '0; stall = 1'b0;
        tick(); tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_imem_req", {31'b0, imem_req}, 32'h1);
        chk("rst_instr_valid", {31'b0, instr_valid}, 32'h0);
        chk("rst_link_we", {31'b0, link_we}, 32'h0);
        chk("rst_link_value", link_value, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        chk("rst_misalign", {31'b0, misalign_err}, 32'h0);
        rst = 1'b0;
        $display("reset done");

        fetch(OP_ALU);
        chk("exec0_valid", {31'b0, instr_valid}, 32'h1);
        chk("exec0_req", {31'b0, imem_req}, 32'h0);
        chk("exec0_pc", pc, 32'h0);
        chk("exec0_instr", instr, {OP_ALU, 26'h0000ABC});
        tick();
        chk("seq_pc4", pc, 32'h4);
        chk("seq_req", {31'b0, imem_req}, 32'h1);
        chk("seq_valid", {31'b0, instr_valid}, 32'h0);
        fetch(OP_ALU); tick(); chk("seq_pc8", pc, 32'h8);
        fetch(OP_ALU); tick(); chk("seq_pcC", pc, 32'hC);
        fetch(OP_ALU); tick(); chk("seq_pc10", pc, 32'h10);
        $display("sequential fetch to 0x10");

        for (int i = 0; i < 3; i++) begin
            tick();
            chk("wait_req", {31'b0, imem_req}, 32'h1);
            chk("wait_pc", pc, 32'h10);
            chk("wait_valid", {31'b0, instr_valid}, 32'h0);
        end
        fetch(OP_BZ);
        chk("wait_exec", {31'b0, instr_valid}, 32'h1);
        branch_valid = 1'b1; imm_offset = 32'd3;
        tick();
        chk("bz_fwd_pc", pc, 32'h20);
        $display("fetch wait then bz +3 -> 0x20");

        fetch(OP_BZ);
        branch_valid = 1'b1; imm_offset = -32'sd3;
        tick();
        chk("bz_back_pc", pc, 32'h18);
        fetch(OP_BZ);
        branch_valid = 1'b0;
        tick();
        chk("bz_nt_pc", pc, 32'h1C);
        fetch(OP_BZ);
        branch_valid = 1'b1; imm_offset = 32'd8;
        tick();
        chk("bz_to40_pc", pc, 32'h40);
        $display("bz -3 -> 0x18, not taken -> 0x1C, +8 -> 0x40");

        stall = 1'b1;
        branch_valid = 1'b1; imm_offset = 32'h10;
        fetch(OP_BL);
        chk("fetch_stall_noeffect", {31'b0, instr_valid}, 32'h1);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("stall_valid", {31'b0, instr_valid}, 32'h1);
            chk("stall_link_we", {31'b0, link_we}, 32'h0);
            chk("stall_pc", pc, 32'h40);
        end
        stall = 1'b0;
        tick();
        branch_valid = 1'b0;
        chk("bl_pc", pc, 32'h84);
        chk("bl_link_we", {31'b0, link_we}, 32'h1);
        chk("bl_link_value", link_value, 32'h44);
        tick();
        chk("bl_pulse_end", {31'b0, link_we}, 32'h0);
        chk("bl_link_hold", link_value, 32'h44);
        $display("bl with 2-cycle stall -> pc 0x84 link 0x44");

        fetch(OP_BR);
        branch_valid = 1'b1; rs_value = 32'hFFFF_FFFC;
        tick();
        chk("br_high_pc", pc, 32'hFFFF_FFFC);
        fetch(OP_ALU);
        branch_valid = 1'b0;
        tick();
        chk("wrap_pc", pc, 32'h0);
        $display("br to 0xFFFFFFFC then wrap to 0");

        fetch(OP_BR);
        branch_valid = 1'b1; rs_value = 32'h102;
        tick();
        branch_valid = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        chk("mis_halted", {31'b0, halted}, 32'h1);
        chk("mis_flag", {31'b0, misalign_err}, 32'h1);
        chk("mis_pc", pc, 32'h0);
        chk("mis_req", {31'b0, imem_req}, 32'h0);
        $display("br 0x102 misaligned -> halt");
`else
        chk("br_align_pc", pc, 32'h100);
        chk("br_align_flag", {31'b0, misalign_err}, 32'h0);
        chk("br_align_halted", {31'b0, halted}, 32'h0);
        fetch(OP_HALT);
        tick();
        chk("halt_halted", {31'b0, halted}, 32'h1);
        chk("halt_req", {31'b0, imem_req}, 32'h0);
        chk("halt_valid", {31'b0, instr_valid}, 32'h0);
        chk("halt_pc", pc, 32'h100);
        $display("br 0x102 -> 0x100, then halt");
`endif

        imem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_stay", {31'b0, halted}, 32'h1);
            chk("halt_stay_req", {31'b0, imem_req}, 32'h0);
        end
        imem_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("unhalt_pc", pc, 32'h0);
        chk("unhalt_halted", {31'b0, halted}, 32'h0);
        chk("unhalt_req", {31'b0, imem_req}, 32'h1);
        chk("unhalt_misalign", {31'b0, misalign_err}, 32'h0);
        $display("reset out of halt");

        fetch(OP_BL);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstbl_link_we", {31'b0, link_we}, 32'h0);
        chk("rstbl_link_value", link_value, 32'h0);
        chk("rstbl_pc", pc, 32'h0);
        chk("rstbl_req", {31'b0, imem_req}, 32'h1);
        $display("reset during bl exec");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Program-counter and fetch sequencer for the KGP-miniRISC core. Holds the PC, runs a two-phase FETCH/EXEC handshake with instruction memory, latches the fetched instruction, and at the end of EXEC selects the next PC: sequential, PC-relative branch target, or register target. The selection uses the `branch_valid` produced by the branch-condition stage for the latched opcode. Also produces the link write for `bl` and the processor halt state.

## Interface
- `PC_WIDTH`, 32: PC and address width.
- `RESET_PC`, 32'h0000_0000: PC value loaded on reset.
- `HALT_OPCODE`, 6'b111111: opcode that stops the sequencer.

- `clk` in 1: core clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `imem_ready` in 1: instruction memory has `imem_rdata` valid this cycle.
- `imem_rdata` in 32: fetched instruction word.
- `branch_valid` in 1: branch-condition result for `instr[31:26]`, combinational, valid during EXEC.
- `rs_value` in 32: register operand, used as the target for `br` (opcode 001010).
- `imm_offset` in 32: sign-extended word offset for relative branches.
- `stall` in 1: holds EXEC and prevents the PC update.
- `pc` out PC_WIDTH: address of the current instruction.
- `imem_req` out 1: fetch request; high throughout FETCH.
- `instr` out 32: latched instruction.
- `instr_valid` out 1: high during EXEC.
- `link_we` out 1: one-cycle pulse to write `link_value` into r31.
- `link_value` out 32: return address, pc+4.
- `halted` out 1: sequencer is in HALT.
- `misalign_err` out 1: sticky misaligned-target flag (see Configuration).

## Operation
- States: FETCH, EXEC, HALT. Reset enters FETCH.
- **FETCH**
  - `imem_req`=1.
  - When `imem_ready`=1: `instr`<=`imem_rdata`, go to EXEC.
  - Otherwise remain in FETCH; `pc` is held.
- **EXEC**
  - `instr_valid`=1.
  - If `stall`=1: remain in EXEC; no PC update, no `link_we`.
  - Else if `instr[31:26]`==HALT_OPCODE: go to HALT; `pc` is unchanged.
  - Else compute the next PC and go to FETCH:
    - `branch_valid`=0: next = pc+4.
    - `branch_valid`=1, opcode 001010 (`br`): next = `rs_value`.
    - `branch_valid`=1, any other opcode: next = pc+4+(`imm_offset`<<2).
    - All arithmetic is modulo 2^PC_WIDTH; overflow wraps and no flag is raised.
  - Opcode 001100 (`bl`): `link_we`=1 for the single non-stalled EXEC cycle; `link_value`=pc+4.
- **HALT**
  - Terminal; exited only by `rst`.
  - `halted`=1, `imem_req`=0, `instr_valid`=0.
- Not gated by state: `branch_valid` is ignored outside EXEC. `imem_ready` outside FETCH is ignored.

## Timing
- Reset values: `pc`=RESET_PC, `instr`=0, `imem_req`=1 (FETCH), `instr_valid`=0, `link_we`=0, `link_value`=0, `halted`=0, `misalign_err`=0.
- Minimum instruction period: 2 cycles (FETCH with `imem_ready` high, then EXEC).
- The new `pc` is visible on the cycle after the last EXEC cycle, together with `imem_req`=1.
- `rst` has priority over every other input in every state, including mid-FETCH wait and HALT. A `bl` in EXEC when reset is applied produces no `link_we`.
- `stall` asserted in FETCH has no effect.
- `link_value` is registered and held until the next `bl`.

## Configuration
- `PC_ALIGN_CHECK_EN`
  - Defined: if a `br` target has `rs_value[1:0]`≠0, set `misalign_err` (sticky until `rst`) and enter HALT; `pc` is unchanged.
  - Undefined: `rs_value[1:0]` is forced to 2'b00 in the target, and `misalign_err` is tied to 0.

## Test plan
- Reset, then `imem_ready`=1 every cycle with non-branch opcodes and `branch_valid`=0 -> `pc` reads 0, 4, 8, advancing once every 2 cycles.
- `imem_ready` low for 3 cycles in FETCH at pc=0x10 -> `imem_req` stays high, `pc` stays 0x10, `instr_valid`=0 until the cycle after `imem_ready` rises.
- bz at pc=0x20, `branch_valid`=1, `imm_offset`=-3 -> next pc=0x18; with `branch_valid`=0 -> next pc=0x24.
- bl at pc=0x40, `imm_offset`=0x10, `stall` high for 2 EXEC cycles -> a single `link_we` pulse after the stall releases, `link_value`=0x44, next pc=0x84.
- br with `rs_value`=0x102 -> with the macro: `misalign_err`=1, `halted`=1, pc=0x102 is never issued. Without the macro: next pc=0x100.
- HALT_OPCODE fetched at pc=0x30 -> `halted`=1, `imem_req`=0 indefinitely. Asserting `rst` -> next cycle pc=RESET_PC, `halted`=0, `imem_req`=1.
